mmu_sequencer: RTL
==================

MMU_SEQUENCER -- requirements
Module: mmu_sequencer

Interface
REQ-001 Parameter WIDTH, default 8: element width in bits.
REQ-002 Parameter LENGTH, default 256: systolic array dimension (LENGTH x LENGTH PEs).
REQ-003 Parameter NW, default 16: width of the row-count field.
REQ-004 CLK  in  1  sole clock; all state updates on the rising edge.
REQ-005 ASYNC_RST  in  1  asynchronous, active-high reset.
REQ-006 SYNC_RST  in  1  synchronous, active-high clear; same effect as ASYNC_RST, applied at the next edge.
REQ-007 start  in  1  command strobe; accepted only in IDLE.
REQ-008 num_rows  in  NW  number of input vectors N, sampled when start is accepted.
REQ-009 w_valid, w_ready  in/out  1 each  weight-row handshake.
REQ-010 w_data  in  WIDTH*LENGTH  weight row.
REQ-011 x_valid, x_ready  in/out  1 each  input-vector handshake.
REQ-012 x_data  in  WIDTH*LENGTH  input vector; lane 0 occupies the MSBs.
REQ-013 arr_en  out  1  EN to the array.
REQ-014 arr_inputs  out  WIDTH*LENGTH  skewed Inputs bus to the array.
REQ-015 arr_weights  out  WIDTH*LENGTH  Weights bus to the array.
REQ-016 out_valid  out  1  result-row strobe.
REQ-017 out_row  out  NW  index of the row presented on the current out_valid cycle.
REQ-018 busy, done, err  out  1 each  status; done and err are single-cycle pulses.

Function
REQ-019 The FSM SHALL have exactly five states: IDLE, LOAD_W, STREAM, DRAIN, FIN.
REQ-020 IDLE: start with N>0 SHALL be accepted, latch N, and enter LOAD_W on the next cycle.
REQ-021 IDLE: start with N=0 SHALL pulse err one cycle later and remain in IDLE.
REQ-022 start outside IDLE SHALL be ignored, with no err pulse.
REQ-023 LOAD_W: w_ready=1.
REQ-024 LOAD_W: each w_valid&&w_ready beat SHALL drive arr_weights=w_data and arr_en=1 in that same cycle.
REQ-025 LOAD_W: after exactly LENGTH beats the FSM SHALL enter STREAM; a cycle with w_valid=0 SHALL hold arr_en=0 and leave the beat count unchanged.
REQ-026 STREAM: x_ready=1; each x_valid&&x_ready beat SHALL assert arr_en=1 and advance the skew line.
REQ-027 STREAM: after N beats the FSM SHALL enter DRAIN; a cycle with x_valid=0 SHALL stall the skew line and array (arr_en=0).
REQ-028 Skew: lane i of arr_inputs SHALL present lane i of the vector accepted i enabled beats earlier, giving 0..LENGTH-1 beat delay, lane 0 undelayed.
REQ-029 DRAIN: the skew line SHALL be fed zero vectors with arr_en=1 every cycle for exactly 2*LENGTH-2 cycles, then the FSM SHALL enter FIN.
REQ-030 FIN: done=1 for one cycle, then IDLE.
REQ-031 Beat index k counts enabled STREAM and DRAIN beats from 0.
REQ-032 out_valid SHALL be registered and assert one cycle after each enabled beat with 2*LENGTH-2 <= k <= 2*LENGTH-3+N, with out_row = k-(2*LENGTH-2).
REQ-033 Total out_valid pulses per command SHALL equal N.
REQ-034 Outside LOAD_W, arr_weights SHALL be 0.
REQ-035 Outside STREAM and DRAIN, arr_inputs SHALL be 0.
REQ-036 busy=1 in every state except IDLE.
REQ-037 w_ready and x_ready SHALL never be asserted outside their respective states.

Reset
REQ-038 On ASYNC_RST or SYNC_RST: state=IDLE, all counters=0, skew line cleared, and every output equals 0.
REQ-039 Reset mid-operation SHALL abandon the command with no done pulse and no further out_valid pulses.

Structure
REQ-040 A shared package SHALL hold the state encoding and the DRAIN_CYCLES=2*LENGTH-2 constant.
REQ-041 The triangular delay SHALL be a single sub-module skew_line(WIDTH, LENGTH) with an enable-gated shift.
REQ-042 Counters SHALL be sized by $clog2 of their maximum value, with no wrap inside one command.

Verification
REQ-043 LENGTH=4, N=3, valids held high: arr_en high for 4+3+6 cycles; out_valid at k=6,7,8 with out_row 0,1,2; done pulses once.
REQ-044 LENGTH=4, N=2: lane3 of vector 0=0x11 appears on arr_inputs lane3 exactly 3 enabled beats after acceptance.
REQ-045 x_valid low for 2 cycles mid-STREAM: arr_en low for those 2 cycles, skew contents frozen, out_row sequence unchanged.
REQ-046 start with num_rows=0: err pulse, busy stays 0; start during STREAM: ignored.
REQ-047 ASYNC_RST asserted in DRAIN: all outputs 0 immediately; a subsequent command completes normally.
REQ-048 SYNC_RST in LOAD_W after 2 weight beats: IDLE next edge, w_ready=0.

Source files
------------

// File: rtl/mmu_sequencer_pkg.sv
// Shared definitions for the systolic-array sequencer: FSM encoding and drain length.
package mmu_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN,
    FIN
  } seq_state_e;

  // DRAIN_CYCLES = 2*LENGTH-2: zero beats needed to flush the skew line and the array diagonal.
  function automatic int unsigned drain_cycles(input int unsigned length);
    return 2 * length - 2;
  endfunction

endpackage

// File: rtl/mmu_sequencer_skew_line.sv
// Triangular delay line: lane i is delayed by i enabled beats, lane 0 passes straight through.
module skew_line #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned LENGTH = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic [WIDTH*LENGTH-1:0] in_i,
  output logic [WIDTH*LENGTH-1:0] out_o
);

  localparam int unsigned BUS_W = WIDTH * LENGTH;

  assign out_o[BUS_W-1 -: WIDTH] = in_i[BUS_W-1 -: WIDTH];

  for (genvar i = 1; i < LENGTH; i++) begin : g_lane
    logic [WIDTH-1:0] tap_q [0:i-1];

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int j = 0; j < i; j++) tap_q[j] <= '0;
      end else if (clr_i) begin
        for (int j = 0; j < i; j++) tap_q[j] <= '0;
      end else if (en_i) begin
        tap_q[0] <= in_i[BUS_W-1-WIDTH*i -: WIDTH];
        for (int j = 1; j < i; j++) tap_q[j] <= tap_q[j-1];
      end
    end

    assign out_o[BUS_W-1-WIDTH*i -: WIDTH] = tap_q[i-1];
  end

endmodule

// File: rtl/mmu_sequencer.sv
// Sequencer for a LENGTH x LENGTH systolic array: loads weights, streams skewed inputs, drains results.
module mmu_sequencer
  import mmu_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned LENGTH = 256,
  parameter int unsigned NW     = 16
) (
  input  logic                    CLK,
  input  logic                    ASYNC_RST,
  input  logic                    SYNC_RST,
  input  logic                    start,
  input  logic [NW-1:0]           num_rows,
  input  logic                    w_valid,
  output logic                    w_ready,
  input  logic [WIDTH*LENGTH-1:0] w_data,
  input  logic                    x_valid,
  output logic                    x_ready,
  input  logic [WIDTH*LENGTH-1:0] x_data,
  output logic                    arr_en,
  output logic [WIDTH*LENGTH-1:0] arr_inputs,
  output logic [WIDTH*LENGTH-1:0] arr_weights,
  output logic                    out_valid,
  output logic [NW-1:0]           out_row,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int unsigned BUS_W        = WIDTH * LENGTH;
  localparam int unsigned DRAIN_CYCLES = drain_cycles(LENGTH);
  localparam int unsigned WCW          = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int unsigned KW           = $clog2((2 ** NW) + DRAIN_CYCLES);

  seq_state_e       state_q, state_d;
  logic [NW-1:0]    n_q, n_d;
  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic [KW-1:0]    k_q, k_d;
  logic             out_valid_q, out_valid_d;
  logic [NW-1:0]    out_row_q, out_row_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  logic             beat;
  logic [BUS_W-1:0] skew_in;
  logic [BUS_W-1:0] skew_out;

  skew_line #(
    .WIDTH  (WIDTH),
    .LENGTH (LENGTH)
  ) u_skew (
    .clk_i (CLK),
    .rst_i (ASYNC_RST),
    .clr_i (SYNC_RST),
    .en_i  (beat),
    .in_i  (skew_in),
    .out_o (skew_out)
  );

  always_ff @(posedge CLK or posedge ASYNC_RST) begin
    if (ASYNC_RST) begin
      state_q     <= IDLE;
      n_q         <= '0;
      wcnt_q      <= '0;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      wcnt_q      <= wcnt_d;
      k_q         <= k_d;
      out_valid_q <= out_valid_d;
      out_row_q   <= out_row_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    wcnt_d      = wcnt_q;
    k_d         = k_q;
    out_valid_d = 1'b0;
    out_row_d   = '0;
    err_d       = 1'b0;
    beat        = 1'b0;
    skew_in     = '0;
    w_ready     = 1'b0;
    x_ready     = 1'b0;
    arr_en      = 1'b0;
    arr_weights = '0;
    arr_inputs  = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (num_rows != '0) begin
            n_d     = num_rows;
            state_d = LOAD_W;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD_W: begin
        w_ready = 1'b1;
        if (w_valid) begin
          arr_en      = 1'b1;
          arr_weights = w_data;
          if (wcnt_q == WCW'(LENGTH - 1)) begin
            wcnt_d  = '0;
            state_d = STREAM;
          end else begin
            wcnt_d = wcnt_q + WCW'(1);
          end
        end
      end
      STREAM: begin
        x_ready = 1'b1;
        if (x_valid) begin
          beat    = 1'b1;
          skew_in = x_data;
          if (k_q == KW'(n_q) - KW'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        beat = 1'b1;
        if (k_q == KW'(n_q) + KW'(DRAIN_CYCLES - 1)) state_d = FIN;
      end
      FIN: begin
        k_d     = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Results leave the array once the diagonal has filled; one row per enabled beat.
    if (beat) begin
      arr_en = 1'b1;
      k_d    = k_q + KW'(1);
      if (k_q >= KW'(DRAIN_CYCLES) && k_q < KW'(n_q) + KW'(DRAIN_CYCLES)) begin
        out_valid_d = 1'b1;
        out_row_d   = NW'(k_q - KW'(DRAIN_CYCLES));
      end
    end

    if (state_q == STREAM || state_q == DRAIN) arr_inputs = skew_out;

    if (SYNC_RST) begin
      state_d     = IDLE;
      n_d         = '0;
      wcnt_d      = '0;
      k_d         = '0;
      out_valid_d = 1'b0;
      out_row_d   = '0;
      err_d       = 1'b0;
    end

    done_d = (state_d == FIN);
    busy_d = (state_d != IDLE);
  end

  assign out_valid = out_valid_q;
  assign out_row   = out_row_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = busy_q;

endmodule
